// File: rtl/test_monitor_pkg.sv
// Shared constants for the test monitor: result codes, the RISC-V
// ECALL/EBREAK encodings that end a run, and the monitor FSM state encoding.
package test_monitor_pkg;

    // Result codes reported on the status output
    typedef enum logic [2:0] {
        STAT_RUNNING = 3'd0,
        STAT_PASS    = 3'd1,
        STAT_FAIL    = 3'd2,
        STAT_TIMEOUT = 3'd3,
        STAT_BREAK   = 3'd4,
        STAT_HANG    = 3'd5
    } status_e;

    // Monitor FSM states
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/test_monitor_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
// Ports: clk/rst_n (async active-low clear), clr (synchronous clear, wins over
// en), en (count enable), q (registered count).
module sat_counter
    import test_monitor_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next-count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (en && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/test_monitor.sv
// test_monitor: watches the fetch stream of a core under test and decides
// when a run is over (ECALL pass, EBREAK fail, PC breakpoint, PC hang or
// cycle timeout). The result is latched and held until clear or reset.
// Ports: sysClk/sysRes (clock, async active-low reset), clear (sync restart),
// instrValid/instrData/pc (fetch stream), bpEn/bpAddr (breakpoint channels),
// done/status/bpIdx (registered result), cycleCnt/retiredCnt (run counters).
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 50000,
    parameter int HANG_LIMIT = 1024,
    parameter int NUM_BP     = 4,
    localparam int BP_W      = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                   sysClk,
    input  logic                   sysRes,
    input  logic                   clear,
    input  logic                   instrValid,
    input  logic [XLEN-1:0]        instrData,
    input  logic [XLEN-1:0]        pc,
    input  logic [NUM_BP-1:0]      bpEn,
    input  logic [NUM_BP*XLEN-1:0] bpAddr,
    output logic                   done,
    output logic [2:0]             status,
    output logic [BP_W-1:0]        bpIdx,
    output logic [CNT_W-1:0]       cycleCnt,
    output logic [CNT_W-1:0]       retiredCnt
);

    // Wide enough to hold HANG_LIMIT itself, so the stall counter never
    // saturates before the hang is declared.
    localparam int          HANG_W    = $clog2(HANG_LIMIT + 1);
    localparam logic [63:0] TO_TARGET = 64'(TIMEOUT - 1);

    state_e            state_q, state_d;
    status_e           status_q, status_d;
    logic              done_q, done_d;
    logic [BP_W-1:0]   bp_idx_q, bp_idx_d;
    logic [XLEN-1:0]   last_pc_q, last_pc_d;
    logic              last_pc_vld_q, last_pc_vld_d;

    logic [CNT_W-1:0]  cycle_cnt_s;
    logic [CNT_W-1:0]  retired_cnt_s;
    logic [HANG_W-1:0] stall_cnt_s;

    logic              run_s;
    logic              same_pc_s;
    logic              stall_en_s;
    logic              stall_clr_s;
    logic [NUM_BP-1:0] bp_hit_s;
    logic [BP_W-1:0]   bp_enc_s;
    logic              pass_ev_s, fail_ev_s, brk_ev_s, hang_ev_s, timeout_ev_s;

    assign run_s     = (state_q == ST_RUN);
    assign same_pc_s = last_pc_vld_q && (pc == last_pc_q);

    // A repeat of the last valid PC extends the stall; a new PC restarts it.
    // Invalid cycles leave it untouched.
    assign stall_en_s  = run_s && !clear && instrValid && same_pc_s;
    assign stall_clr_s = clear || (run_s && instrValid && !same_pc_s);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (sysClk),
        .rst_n (sysRes),
        .clr   (clear),
        .en    (run_s),
        .q     (cycle_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_retired_cnt (
        .clk   (sysClk),
        .rst_n (sysRes),
        .clr   (clear),
        .en    (run_s && instrValid),
        .q     (retired_cnt_s)
    );

    sat_counter #(.W(HANG_W)) u_stall_cnt (
        .clk   (sysClk),
        .rst_n (sysRes),
        .clr   (stall_clr_s),
        .en    (stall_en_s),
        .q     (stall_cnt_s)
    );

    // Per-channel breakpoint comparators
    for (genvar k = 0; k < NUM_BP; k++) begin : g_bp
        assign bp_hit_s[k] = bpEn[k] && (pc == bpAddr[k*XLEN +: XLEN]);
    end

    // Lowest-index priority encoder: scanning downward lets low channels win
    always_comb begin
        bp_enc_s = {BP_W{1'b0}};
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            bp_enc_s = bp_hit_s[k] ? BP_W'(k) : bp_enc_s;
        end
    end

    assign pass_ev_s = instrValid && (instrData == XLEN'(INSN_ECALL));
    assign fail_ev_s = instrValid && (instrData == XLEN'(INSN_EBREAK));
    assign brk_ev_s  = instrValid && (|bp_hit_s);
    // The stall counter reaches HANG_LIMIT on this edge
    assign hang_ev_s = stall_en_s && (stall_cnt_s == HANG_W'(HANG_LIMIT - 1));
    // The cycle counter reaches TIMEOUT-1 on this edge (never once saturated)
    assign timeout_ev_s = !(&cycle_cnt_s) &&
                          ((64'(cycle_cnt_s) + 64'd1) == TO_TARGET);

    // Last-valid-PC tracking for hang detection
    always_comb begin
        last_pc_d     = last_pc_q;
        last_pc_vld_d = last_pc_vld_q;
        if (clear) begin
            last_pc_d     = {XLEN{1'b0}};
            last_pc_vld_d = 1'b0;
        end else if (run_s && instrValid) begin
            last_pc_d     = pc;
            last_pc_vld_d = 1'b1;
        end else begin
            last_pc_d     = last_pc_q;
            last_pc_vld_d = last_pc_vld_q;
        end
    end

    // FSM next-state and result latch; priority FAIL > PASS > BREAK > HANG > TIMEOUT
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        done_d   = done_q;
        bp_idx_d = bp_idx_q;
        if (clear) begin
            state_d  = ST_RUN;
            status_d = STAT_RUNNING;
            done_d   = 1'b0;
            bp_idx_d = {BP_W{1'b0}};
        end else if (run_s) begin
            if (fail_ev_s) begin
                state_d  = ST_DONE;
                status_d = STAT_FAIL;
                done_d   = 1'b1;
            end else if (pass_ev_s) begin
                state_d  = ST_DONE;
                status_d = STAT_PASS;
                done_d   = 1'b1;
            end else if (brk_ev_s) begin
                state_d  = ST_DONE;
                status_d = STAT_BREAK;
                done_d   = 1'b1;
                bp_idx_d = bp_enc_s;
            end else if (hang_ev_s) begin
                state_d  = ST_DONE;
                status_d = STAT_HANG;
                done_d   = 1'b1;
            end else if (timeout_ev_s) begin
                state_d  = ST_DONE;
                status_d = STAT_TIMEOUT;
                done_d   = 1'b1;
            end else begin
                state_d  = ST_RUN;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and result registers
    always_ff @(posedge sysClk or negedge sysRes) begin
        if (!sysRes) begin
            state_q       <= ST_RUN;
            status_q      <= STAT_RUNNING;
            done_q        <= 1'b0;
            bp_idx_q      <= {BP_W{1'b0}};
            last_pc_q     <= {XLEN{1'b0}};
            last_pc_vld_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            done_q        <= done_d;
            bp_idx_q      <= bp_idx_d;
            last_pc_q     <= last_pc_d;
            last_pc_vld_q <= last_pc_vld_d;
        end
    end

    assign done       = done_q;
    assign status     = status_q;
    assign bpIdx      = bp_idx_q;
    assign cycleCnt   = cycle_cnt_s;
    assign retiredCnt = retired_cnt_s;

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor. dut_a uses a short timeout and hang limit;
// dut_b shares the stimulus with 4-bit counters to show saturation.
module tb_test_monitor;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic         sysClk = 1'b0;
    logic         sysRes;
    logic         clear;
    logic         instrValid;
    logic [31:0]  instrData;
    logic [31:0]  pc;
    logic [3:0]   bpEn;
    logic [127:0] bpAddr;

    logic        done_a, done_b;
    logic [2:0]  status_a, status_b;
    logic [1:0]  bp_idx_a, bp_idx_b;
    logic [31:0] cyc_a, ret_a;
    logic [3:0]  cyc_b, ret_b;

    int checks   = 0;
    int failures = 0;

    always #5 sysClk = ~sysClk;

    test_monitor #(.XLEN(32), .CNT_W(32), .TIMEOUT(100), .HANG_LIMIT(8), .NUM_BP(4)) dut_a (
        .sysClk(sysClk), .sysRes(sysRes), .clear(clear), .instrValid(instrValid),
        .instrData(instrData), .pc(pc), .bpEn(bpEn), .bpAddr(bpAddr),
        .done(done_a), .status(status_a), .bpIdx(bp_idx_a),
        .cycleCnt(cyc_a), .retiredCnt(ret_a)
    );

    test_monitor #(.XLEN(32), .CNT_W(4), .TIMEOUT(50000), .HANG_LIMIT(1024), .NUM_BP(4)) dut_b (
        .sysClk(sysClk), .sysRes(sysRes), .clear(clear), .instrValid(instrValid),
        .instrData(instrData), .pc(pc), .bpEn(bpEn), .bpAddr(bpAddr),
        .done(done_b), .status(status_b), .bpIdx(bp_idx_b),
        .cycleCnt(cyc_b), .retiredCnt(ret_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] p);
        instrValid = v;
        instrData  = d;
        pc         = p;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drive(1'b0, NOP, 32'h0);
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        sysRes = 1'b0;
        clear  = 1'b0;
        bpEn   = 4'b0000;
        bpAddr = 128'h0;
        drive(1'b0, NOP, 32'h0);
        repeat (2) tick();

        // Reset state
        chk("rst_done",   32'(done_a),   32'd0);
        chk("rst_status", 32'(status_a), 32'd0);
        chk("rst_bpidx",  32'(bp_idx_a), 32'd0);
        chk("rst_cycle",  cyc_a,         32'd0);
        chk("rst_retired", ret_a,        32'd0);
        sysRes = 1'b1;

        // ECALL on the 10th valid fetch
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, (i == 10) ? ECALL : NOP, 32'h100 + 32'(4 * i));
            tick();
            if (i == 9) begin
                chk("pre_ecall_done",    32'(done_a), 32'd0);
                chk("pre_ecall_retired", ret_a,       32'd9);
            end
        end
        chk("ecall_done",    32'(done_a),   32'd1);
        chk("ecall_status",  32'(status_a), 32'd1);
        chk("ecall_retired", ret_a,         32'd10);
        chk("ecall_cycle",   cyc_a,         32'd10);
        drive(1'b1, EBREAK, 32'h200);
        repeat (3) tick();
        chk("hold_status",  32'(status_a), 32'd1);
        chk("hold_retired", ret_a,         32'd10);
        chk("hold_cycle",   cyc_a,         32'd10);

        // clear on the same edge as an ECALL
        clear = 1'b1;
        drive(1'b1, ECALL, 32'h300);
        tick();
        clear = 1'b0;
        chk("clr_done",    32'(done_a),   32'd0);
        chk("clr_status",  32'(status_a), 32'd0);
        chk("clr_cycle",   cyc_a,         32'd0);
        chk("clr_retired", ret_a,         32'd0);
        drive(1'b1, NOP, 32'h304);
        tick();
        chk("post_clr_status", 32'(status_a), 32'd0);
        chk("post_clr_cycle",  cyc_a,         32'd1);

        // EBREAK and breakpoint hit together: FAIL wins
        bpAddr[31:0] = 32'h2000;
        bpEn = 4'b0001;
        drive(1'b1, EBREAK, 32'h2000);
        tick();
        chk("fail_status", 32'(status_a), 32'd2);
        chk("fail_done",   32'(done_a),   32'd1);
        chk("fail_bpidx",  32'(bp_idx_a), 32'd0);

        // Channels 1 and 2 enabled and matching; 0 and 3 match but disabled
        do_clear();
        bpAddr = {4{32'h3000}};
        bpEn   = 4'b0110;
        drive(1'b0, NOP, 32'h3000);
        tick();
        chk("bp_invalid_done", 32'(done_a), 32'd0);
        drive(1'b1, NOP, 32'h3000);
        tick();
        chk("bp_status", 32'(status_a), 32'd4);
        chk("bp_idx",    32'(bp_idx_a), 32'd1);

        // Timeout with only NOPs at changing PCs
        do_clear();
        bpEn = 4'b0000;
        for (int i = 1; i <= 98; i++) begin
            drive(1'b1, NOP, 32'h5000 + 32'(4 * i));
            tick();
        end
        chk("pre_to_done",  32'(done_a), 32'd0);
        chk("pre_to_cycle", cyc_a,       32'd98);
        drive(1'b1, NOP, 32'h6000);
        tick();
        chk("to_status", 32'(status_a), 32'd3);
        chk("to_cycle",  cyc_a,         32'd99);
        drive(1'b1, NOP, 32'h6004);
        tick();
        chk("to_hold_cycle", cyc_a,            32'd99);
        chk("sat_cycle_b",   32'(cyc_b),       32'd15);
        chk("sat_retired_b", 32'(ret_b),       32'd15);
        chk("sat_done_b",    32'(done_b),      32'd0);
        chk("sat_status_b",  32'(status_b),    32'd0);
        chk("sat_bpidx_b",   32'(bp_idx_b),    32'd0);

        // Hang: same PC, valid toggling; 8 valid repeats after the first fetch
        do_clear();
        drive(1'b1, NOP, 32'h4000);
        tick();
        for (int r = 1; r <= 8; r++) begin
            drive(1'b0, NOP, 32'h4000);
            tick();
            drive(1'b1, NOP, 32'h4000);
            tick();
            if (r == 7) begin
                chk("pre_hang_done", 32'(done_a), 32'd0);
            end
        end
        chk("hang_status",  32'(status_a), 32'd5);
        chk("hang_retired", ret_a,         32'd9);
        chk("hang_cycle",   cyc_a,         32'd17);

        // Asynchronous reset while DONE
        sysRes = 1'b0;
        #1;
        chk("arst_done",    32'(done_a),   32'd0);
        chk("arst_status",  32'(status_a), 32'd0);
        chk("arst_cycle",   cyc_a,         32'd0);
        chk("arst_retired", ret_a,         32'd0);
        #2;
        sysRes = 1'b1;
        drive(1'b1, NOP, 32'h7000);
        tick();
        chk("resume_cycle",   cyc_a,       32'd1);
        chk("resume_retired", ret_a,       32'd1);
        chk("resume_done",    32'(done_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
